// File: rtl/regfile_scoreboard.sv
// Multi-write-back register file with per-register busy bits, write-back bypass
// and a one-entry valid/ready operand register feeding the execute units.
module regfile_scoreboard #(
    parameter int REG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WB     = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           issue_valid,
    output logic                           issue_ready,
    input  logic [REG_WIDTH-1:0]           issue_rs1,
    input  logic [REG_WIDTH-1:0]           issue_rs2,
    input  logic                           issue_rd_en,
    input  logic [REG_WIDTH-1:0]           issue_rd,
    input  logic                           issue_dest,
    input  logic [NUM_WB-1:0]              wb_valid,
    input  logic [NUM_WB*REG_WIDTH-1:0]    wb_rd,
    input  logic [NUM_WB*DATA_WIDTH-1:0]   wb_value,
    output logic                           exe_valid,
    input  logic                           exe_ready,
    output logic                           exe_dest,
    output logic [DATA_WIDTH-1:0]          exe_rs1,
    output logic [DATA_WIDTH-1:0]          exe_rs2,
    output logic [(2**REG_WIDTH)-1:0]      busy_vec
);

    localparam int   REG_SIZE = 2**REG_WIDTH;
    localparam logic ZR       = (ZERO_REG != 0);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends on valid on the same interface.

    logic [DATA_WIDTH-1:0] r_regs [REG_SIZE];
    logic [REG_SIZE-1:0]   r_busy;
    logic                  r_exe_valid;
    logic                  r_exe_dest;
    logic [DATA_WIDTH-1:0] r_exe_rs1;
    logic [DATA_WIDTH-1:0] r_exe_rs2;

    logic [REG_SIZE-1:0]   w_wbclr;
    logic [REG_SIZE-1:0]   w_set_mask;
    logic                  w_raw1;
    logic                  w_raw2;
    logic                  w_waw;
    logic                  w_out_free;
    logic                  w_accept;
    logic                  w_set_busy;
    logic [DATA_WIDTH-1:0] w_op1;
    logic [DATA_WIDTH-1:0] w_op2;

    // Later ports overwrite earlier matches, so the highest index wins.
    function automatic logic [DATA_WIDTH-1:0] f_operand(
        input logic [REG_WIDTH-1:0]          idx,
        input logic [DATA_WIDTH-1:0]         arr_val,
        input logic [NUM_WB-1:0]             v,
        input logic [NUM_WB*REG_WIDTH-1:0]   rd,
        input logic [NUM_WB*DATA_WIDTH-1:0]  val
    );
        logic [DATA_WIDTH-1:0] res;
        res = arr_val;
        for (int k = 0; k < NUM_WB; k++) begin
            if (v[k] && (rd[k*REG_WIDTH +: REG_WIDTH] == idx)) begin
                res = val[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (ZR && (idx == '0)) begin
            res = '0;
        end
        return res;
    endfunction

    always_comb begin
        w_wbclr = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k]) begin
                w_wbclr[wb_rd[k*REG_WIDTH +: REG_WIDTH]] = 1'b1;
            end
        end
    end

    assign w_raw1 = r_busy[issue_rs1] & ~w_wbclr[issue_rs1] & ~(ZR && (issue_rs1 == '0));
    assign w_raw2 = r_busy[issue_rs2] & ~w_wbclr[issue_rs2] & ~(ZR && (issue_rs2 == '0));
    assign w_waw  = issue_rd_en & r_busy[issue_rd] & ~w_wbclr[issue_rd]
                  & ~(ZR && (issue_rd == '0));

    assign w_out_free  = ~r_exe_valid | exe_ready;
    assign issue_ready = w_out_free & ~w_raw1 & ~w_raw2 & ~w_waw;
    assign w_accept    = issue_valid & issue_ready;
    assign w_set_busy  = w_accept & issue_rd_en & ~(ZR && (issue_rd == '0));

    always_comb begin
        w_set_mask = '0;
        if (w_set_busy) begin
            w_set_mask[issue_rd] = 1'b1;
        end
    end

    assign w_op1 = f_operand(issue_rs1, r_regs[issue_rs1], wb_valid, wb_rd, wb_value);
    assign w_op2 = f_operand(issue_rs2, r_regs[issue_rs2], wb_valid, wb_rd, wb_value);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_SIZE; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_valid[k] && !(ZR && (wb_rd[k*REG_WIDTH +: REG_WIDTH] == '0))) begin
                    r_regs[wb_rd[k*REG_WIDTH +: REG_WIDTH]] <= wb_value[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // A new producer claiming rd outranks a write-back retiring the old one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_wbclr) | w_set_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exe_valid <= 1'b0;
            r_exe_dest  <= 1'b0;
            r_exe_rs1   <= '0;
            r_exe_rs2   <= '0;
        end else if (w_accept) begin
            r_exe_valid <= 1'b1;
            r_exe_dest  <= issue_dest;
            r_exe_rs1   <= w_op1;
            r_exe_rs2   <= w_op2;
        end else if (exe_ready) begin
            r_exe_valid <= 1'b0;
        end
    end

    assign exe_valid = r_exe_valid;
    assign exe_dest  = r_exe_dest;
    assign exe_rs1   = r_exe_rs1;
    assign exe_rs2   = r_exe_rs2;
    assign busy_vec  = r_busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: operand bundles are predicted at issue
// time into a queue and checked when the execute side consumes them.
module tb_regfile_scoreboard;

    localparam int RW = 5;
    localparam int DW = 32;
    localparam int NW = 2;
    localparam int BW = 2*DW + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              issue_valid;
    logic              issue_ready;
    logic [RW-1:0]     issue_rs1;
    logic [RW-1:0]     issue_rs2;
    logic              issue_rd_en;
    logic [RW-1:0]     issue_rd;
    logic              issue_dest;
    logic [NW-1:0]     wb_valid;
    logic [NW*RW-1:0]  wb_rd;
    logic [NW*DW-1:0]  wb_value;
    logic              exe_valid;
    logic              exe_ready;
    logic              exe_dest;
    logic [DW-1:0]     exe_rs1;
    logic [DW-1:0]     exe_rs2;
    logic [(2**RW)-1:0] busy_vec;

    logic [BW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    regfile_scoreboard #(
        .REG_WIDTH(RW), .DATA_WIDTH(DW), .NUM_WB(NW), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd_en(issue_rd_en), .issue_rd(issue_rd), .issue_dest(issue_dest),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_value(wb_value),
        .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_dest(exe_dest),
        .exe_rs1(exe_rs1), .exe_rs2(exe_rs2), .busy_vec(busy_vec)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: one bundle consumed per negedge with valid & ready
    always @(negedge clk) begin
        if (rst_n && exe_valid && exe_ready) begin
            if (exp_q.size() == 0) begin
                chk("bundle_unexpected", {exe_dest, exe_rs1, exe_rs2}, 72'h0);
            end else begin
                chk("bundle", {exe_dest, exe_rs1, exe_rs2}, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        issue_valid = 1'b0;
        issue_rs1   = '0;
        issue_rs2   = '0;
        issue_rd_en = 1'b0;
        issue_rd    = '0;
        issue_dest  = 1'b0;
        wb_valid    = '0;
        wb_rd       = '0;
        wb_value    = '0;
    endtask

    task automatic drive_issue(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                               input logic rd_en, input logic [RW-1:0] rd, input logic dest);
        issue_valid = 1'b1;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        issue_rd_en = rd_en;
        issue_rd    = rd;
        issue_dest  = dest;
    endtask

    task automatic set_wb(input int port, input logic [RW-1:0] rd, input logic [DW-1:0] val);
        wb_valid[port]         = 1'b1;
        wb_rd[port*RW +: RW]   = rd;
        wb_value[port*DW +: DW] = val;
    endtask

    task automatic push(input logic dest, input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_q.push_back({dest, a, b});
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        @(negedge clk);
        chk(tag, {71'h0, issue_ready}, {71'h0, exp});
    endtask

    initial begin
        rst_n     = 1'b1;
        exe_ready = 1'b1;
        clr_inputs();
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_exe_valid", {71'h0, exe_valid}, 72'h0);
        chk("rst_exe_dest", {71'h0, exe_dest}, 72'h0);
        chk("rst_busy", {40'h0, busy_vec}, 72'h0);
        chk("rst_rs1", {40'h0, exe_rs1}, 72'h0);
        chk("rst_rs2", {40'h0, exe_rs2}, 72'h0);

        // reset mid-run discards array contents, busy bits and in-flight bundle
        rst_n = 1'b1;
        set_wb(0, 5'd3, 32'h55);
        tick();
        clr_inputs();
        drive_issue(5'd0, 5'd0, 1'b1, 5'd4, 1'b0);
        chk_ready("mid_issue_ready", 1'b1);
        push(1'b0, 32'h0, 32'h0);
        tick();
        clr_inputs();
        chk("mid_busy4", {40'h0, busy_vec}, 72'h10);
        chk("mid_exe_valid", {71'h0, exe_valid}, 72'h1);
        exe_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {40'h0, busy_vec}, 72'h0);
        chk("mid_rst_valid", {71'h0, exe_valid}, 72'h0);
        exp_q.delete();
        tick();
        rst_n     = 1'b1;
        exe_ready = 1'b1;
        drive_issue(5'd3, 5'd3, 1'b0, 5'd0, 1'b0);
        chk_ready("r3_issue_ready", 1'b1);
        push(1'b0, 32'h0, 32'h0);
        tick();
        clr_inputs();

        // basic write then read
        set_wb(0, 5'd5, 32'h1234);
        tick();
        clr_inputs();
        drive_issue(5'd5, 5'd0, 1'b0, 5'd0, 1'b1);
        chk_ready("basic_ready", 1'b1);
        push(1'b1, 32'h1234, 32'h0);
        tick();
        clr_inputs();
        chk("basic_valid", {71'h0, exe_valid}, 72'h1);

        // RAW stall, released by a same-cycle bypass on port 1
        drive_issue(5'd0, 5'd0, 1'b1, 5'd7, 1'b0);
        push(1'b0, 32'h0, 32'h0);
        tick();
        drive_issue(5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
        chk("raw_busy7", {40'h0, busy_vec}, 72'h80);
        chk_ready("raw_stall_a", 1'b0);
        tick();
        chk_ready("raw_stall_b", 1'b0);
        tick();
        set_wb(1, 5'd7, 32'hABCD);
        chk_ready("raw_bypass_ready", 1'b1);
        push(1'b0, 32'hABCD, 32'h0);
        tick();
        clr_inputs();
        chk("raw_busy_clear", {40'h0, busy_vec}, 72'h0);

        // WAW stall, then set-wins against a same-cycle write-back
        drive_issue(5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
        push(1'b0, 32'h0, 32'h0);
        tick();
        drive_issue(5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
        chk_ready("waw_stall", 1'b0);
        tick();
        set_wb(0, 5'd9, 32'h99);
        chk_ready("waw_release", 1'b1);
        push(1'b0, 32'h0, 32'h0);
        tick();
        clr_inputs();
        chk("waw_set_wins", {40'h0, busy_vec}, 72'h200);
        set_wb(0, 5'd9, 32'h77);
        tick();
        clr_inputs();
        chk("waw_final_clear", {40'h0, busy_vec}, 72'h0);

        // back-pressure: bundle held for 3 cycles, then next instruction accepted
        drive_issue(5'd5, 5'd9, 1'b0, 5'd0, 1'b1);
        exe_ready = 1'b0;
        chk_ready("bp_first_accept", 1'b1);
        push(1'b1, 32'h1234, 32'h77);
        tick();
        drive_issue(5'd3, 5'd5, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_ready("bp_hold_ready", 1'b0);
            chk("bp_hold_valid", {71'h0, exe_valid}, 72'h1);
            chk("bp_hold_rs1", {40'h0, exe_rs1}, 72'h1234);
            chk("bp_hold_rs2", {40'h0, exe_rs2}, 72'h77);
            tick();
        end
        exe_ready = 1'b1;
        push(1'b0, 32'h0, 32'h1234);
        chk_ready("bp_release_ready", 1'b1);
        tick();
        clr_inputs();
        chk("bp_second_valid", {71'h0, exe_valid}, 72'h1);

        // dual-port conflict on r2, then register 0 write and busy ignored
        set_wb(0, 5'd2, 32'h1);
        set_wb(1, 5'd2, 32'h2);
        drive_issue(5'd2, 5'd0, 1'b0, 5'd0, 1'b0);
        chk_ready("dual_ready", 1'b1);
        push(1'b0, 32'h2, 32'h0);
        tick();
        clr_inputs();
        set_wb(1, 5'd0, 32'hDEAD);
        drive_issue(5'd0, 5'd2, 1'b0, 5'd0, 1'b0);
        push(1'b0, 32'h0, 32'h2);
        tick();
        clr_inputs();
        drive_issue(5'd2, 5'd0, 1'b1, 5'd0, 1'b1);
        chk_ready("r0_rd_ready", 1'b1);
        push(1'b1, 32'h2, 32'h0);
        tick();
        clr_inputs();
        chk("r0_never_busy", {40'h0, busy_vec}, 72'h0);

        repeat (3) tick();
        chk("drain_valid", {71'h0, exe_valid}, 72'h0);
        chk("queue_empty", 72'(exp_q.size()), 72'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-write-port architectural register file.
- Adds multiple write-back ports, per-register busy bits for RAW/WAW hazard tracking, and same-cycle write-back bypass.
- Operand outputs use a valid/ready handshake.
- Sits between the issue stage and the ALU / load-store execute units. Write-back ports come from the execute units.

Parameters:
- REG_WIDTH, 5: register index width; register count REG_SIZE = 2**REG_WIDTH.
- DATA_WIDTH, 32: register data width.
- NUM_WB, 2: number of independent write-back ports.
- ZERO_REG, 1: when 1, register 0 reads as 0, ignores writes and is never marked busy.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  issue stage presents an instruction.
- issue_ready  out  1  instruction accepted this cycle when high together with issue_valid.
- issue_rs1  in  REG_WIDTH  source register 1 index.
- issue_rs2  in  REG_WIDTH  source register 2 index.
- issue_rd_en  in  1  instruction writes a destination register.
- issue_rd  in  REG_WIDTH  destination register index.
- issue_dest  in  1  target unit (0 ALU, 1 LS); registered alongside the operands.
- wb_valid  in  NUM_WB  per-port write enable.
- wb_rd  in  NUM_WB*REG_WIDTH  per-port destination index; port k occupies bits [k*REG_WIDTH +: REG_WIDTH].
- wb_value  in  NUM_WB*DATA_WIDTH  per-port write data, packed the same way.
- exe_valid  out  1  operand bundle valid.
- exe_ready  in  1  execute unit consumes the bundle.
- exe_dest  out  1  registered issue_dest.
- exe_rs1  out  DATA_WIDTH  operand 1 value.
- exe_rs2  out  DATA_WIDTH  operand 2 value.
- busy_vec  out  REG_SIZE  current busy bit of every register (debug and issue visibility).

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, busy_vec 0, exe_valid 0, exe_dest 0, exe_rs1 0, exe_rs2 0. Takes effect mid-operation: in-flight operand bundles and busy bits are discarded. The first accept is possible in the first clk edge after rst_n rises.
- Write-back clear set (wbclr): registers named by any wb_valid port this cycle.
- Hazard, combinational:
  - raw1 = busy[rs1] & !wbclr(rs1).
  - raw2 = busy[rs2] & !wbclr(rs2).
  - waw = issue_rd_en & busy[rd] & !wbclr(rd).
  - When ZERO_REG=1, register 0 never produces a hazard.
- issue_ready = (!exe_valid | exe_ready) & !raw1 & !raw2 & !waw. It is combinational and does not depend on issue_valid.
- Accept (issue_valid & issue_ready): on the next edge exe_valid=1, exe_dest=issue_dest, and exe_rs1/exe_rs2 are loaded. Latency is exactly 1 cycle.
- Operand selection, per source:
  - Register 0 with ZERO_REG=1 gives 0.
  - Otherwise, a matching wb port this cycle gives that port's wb_value (bypass).
  - Otherwise, the array value is used.
  - If several ports match, the highest port index wins.
- Output hold: if exe_valid & !exe_ready, exe_* hold their values and issue_ready=0.
- Output drain: if exe_ready & no accept, exe_valid clears next edge.
- Write-back: every valid port writes its register on the edge and clears its busy bit.
  - Duplicate rd across ports: highest index data wins.
  - Writes to register 0 are dropped when ZERO_REG=1.
  - A write-back to a non-busy register still writes; it is not an error.
- Busy set: on accept with issue_rd_en and rd not register 0 (ZERO_REG=1), busy[rd] is set. When a write-back clears the same rd in the same cycle, set wins (the new producer owns rd).
- No internal FSM beyond the one-entry output register (EMPTY / FULL via exe_valid). The array reads are combinational into the registered output.

Test Plan:
- Reset mid-run, then no write-back: write 0x55 to r3 via port 0, issue to set busy r4, assert rst_n=0 → busy_vec=0, exe_valid=0, read of r3 returns 0.
- Basic: wb port0 r5=0x1234; next cycle issue rs1=r5, rs2=r0 → exe_rs1=0x1234 and exe_rs2=0 one cycle later, exe_valid=1.
- RAW stall then bypass:
  - Issue rd=r7 with issue_rd_en=1, then issue rs1=r7 → issue_ready=0 while busy.
  - In the cycle wb port1 writes r7=0xABCD → issue_ready=1, and exe_rs1=0xABCD next cycle.
- WAW and set-wins:
  - With r9 busy, issue rd=r9 → stalled.
  - With a same-cycle wb to r9 → accepted, and busy[9] remains 1 after the edge.
- Back-pressure: exe_ready=0 for 3 cycles after an accept → exe_* stable, issue_ready=0. Then exe_ready=1 → the next instruction is accepted and its bundle appears the following cycle.
- Dual-port conflict: both ports write r2 (port0 0x1, port1 0x2) while issuing rs1=r2 → exe_rs1=0x2, and the array reads r2=0x2 afterwards. A write-back to r0 is ignored (r0 reads 0).
